// File: rtl/qsystop_switch_poller.sv
// Switch poller: an Avalon-MM read master that periodically reads the switch PIO data register.
// It debounces the sampled value, publishes a stable switch state, and latches per-bit change
// events into a sticky edge register with an interrupt output.
//
// Optional feature macro: QSYSTOP_SWITCH_POLL_IRQ_EN
//   defined   -> edge_capture_o / edge_clr_i / irq_o are live
//   undefined -> edge_capture_o and irq_o are tied to 0 and edge_clr_i is ignored
module qsystop_switch_poller #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned POLL_DIV     = 5000,
  parameter int unsigned DEBOUNCE_CNT = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              enable_i,
  output logic [1:0]        avm_address_o,
  output logic              avm_read_o,
  input  logic [31:0]       avm_readdata_i,
  input  logic [DATA_W-1:0] edge_clr_i,
  output logic [DATA_W-1:0] sw_state_o,
  output logic              sw_changed_o,
  output logic [DATA_W-1:0] edge_capture_o,
  output logic              irq_o
);

  // Stable-count register only needs to reach DEBOUNCE_CNT, where it saturates.
  localparam int unsigned    DbW       = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [CNT_W-1:0] TimerLast = CNT_W'(POLL_DIV - 1);
  localparam logic [DbW-1:0]  DbMax     = DbW'(DEBOUNCE_CNT);
  localparam logic [DbW-1:0]  DbOne     = DbW'(1);

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWait,
    StEval
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    timer_q, timer_d;
  logic [DATA_W-1:0]   sample_q, sample_d;
  logic [DATA_W-1:0]   cand_q, cand_d;
  logic [DbW-1:0]      cnt_q, cnt_d;
  logic [DATA_W-1:0]   sw_state_q, sw_state_d;
  logic                sw_changed_q, sw_changed_d;
  logic [DATA_W-1:0]   new_edges;
  logic                tick;

  // The PIO data register is the only target.
  assign avm_address_o = 2'b00;

  // Gated by enable so a stale terminal count cannot launch a read in the first disabled cycle.
  assign tick = enable_i && (timer_q == TimerLast);

  // Poll timer: free-running modulo POLL_DIV while enabled, parked at 0 otherwise.
  always_comb begin
    timer_d = timer_q;
    if (!enable_i) begin
      timer_d = '0;
    end else if (timer_q == TimerLast) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + CNT_W'(1);
    end
  end

  // Bus sequencing, sample capture and debounce/commit decisions.
  always_comb begin
    state_d      = state_q;
    sample_d     = sample_q;
    cand_d       = cand_q;
    cnt_d        = cnt_q;
    sw_state_d   = sw_state_q;
    sw_changed_d = 1'b0;
    new_edges    = '0;
    avm_read_o   = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Ticks seen in any other state are simply dropped.
        if (tick) begin
          state_d = StRead;
        end
      end

      StRead: begin
        avm_read_o = 1'b1;
        state_d    = StWait;
      end

      StWait: begin
        // Slave registers its readdata, so it is valid exactly one cycle after the strobe.
        sample_d = avm_readdata_i[DATA_W-1:0];
        state_d  = StEval;
      end

      StEval: begin
        if (sample_q == cand_q) begin
          cnt_d = (cnt_q >= DbMax) ? DbMax : cnt_q + DbOne;
        end else begin
          cand_d = sample_q;
          cnt_d  = DbOne;
        end
        if ((cnt_d >= DbMax) && (cand_d != sw_state_q)) begin
          sw_state_d   = cand_d;
          sw_changed_d = 1'b1;
          new_edges    = cand_d ^ sw_state_q;
        end
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers; reset discards any in-flight read.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      timer_q      <= '0;
      sample_q     <= '0;
      cand_q       <= '0;
      cnt_q        <= '0;
      sw_state_q   <= '0;
      sw_changed_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      sample_q     <= sample_d;
      cand_q       <= cand_d;
      cnt_q        <= cnt_d;
      sw_state_q   <= sw_state_d;
      sw_changed_q <= sw_changed_d;
    end
  end

  assign sw_state_o   = sw_state_q;
  assign sw_changed_o = sw_changed_q;

`ifdef QSYSTOP_SWITCH_POLL_IRQ_EN
  logic [DATA_W-1:0] edge_q, edge_d;
  logic              irq_q;

  // Sticky edges: clear first, then OR in new edges so a same-cycle set wins.
  always_comb begin
    edge_d = (edge_q & ~edge_clr_i) | new_edges;
  end

  // Edge register and interrupt; irq trails edge_capture by one cycle.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      edge_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      edge_q <= edge_d;
      irq_q  <= |edge_q;
    end
  end

  assign edge_capture_o = edge_q;
  assign irq_o          = irq_q;
`else
  logic unused_edge;
  assign unused_edge    = ^{edge_clr_i, new_edges};
  assign edge_capture_o = '0;
  assign irq_o          = 1'b0;
`endif

  // Upper readdata bits carry nothing for an 8-bit PIO.
  logic unused_rdata;
  assign unused_rdata = ^avm_readdata_i;

  // Read strobe never lasts more than one cycle.
  a_read_single : assert property (@(posedge clk_i) disable iff (reset_i)
    avm_read_o |=> !avm_read_o);

  // Parameter sanity.
  a_poll_div : assert property (@(posedge clk_i) (POLL_DIV >= 4) && ((64'(1) << CNT_W) >= 64'(POLL_DIV)));
  a_db_cnt   : assert property (@(posedge clk_i) DEBOUNCE_CNT >= 1);

endmodule

// File: tb/tb_qsystop_switch_poller.sv
// Self-checking bench for qsystop_switch_poller with a registered PIO slave model and a
// scoreboard of expected sw_state/sw_changed per poll. Edge/irq expectations follow
// QSYSTOP_SWITCH_POLL_IRQ_EN.
module tb_qsystop_switch_poller;

  localparam int PollDiv = 8;
  localparam int DbCnt   = 4;
`ifdef QSYSTOP_SWITCH_POLL_IRQ_EN
  localparam bit IrqEn = 1'b1;
`else
  localparam bit IrqEn = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        enable;
  logic [1:0]  avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic [7:0]  edge_clr;
  logic [7:0]  sw_state;
  logic        sw_changed;
  logic [7:0]  edge_capture;
  logic        irq;

  // PIO slave stimulus.
  logic [7:0] pio_val;
  logic       alt_mode;
  logic       alt_phase;
  logic [7:0] pio_ret;

  int n_checks = 0;
  int n_fail   = 0;
  int n_reads  = 0;
  int chg_count = 0;
  int ncyc     = 0;

  typedef struct {
    int         due;
    logic [7:0] st;
    logic       chg;
  } sb_entry_t;
  sb_entry_t sb_q[$];

  qsystop_switch_poller #(
    .DATA_W      (8),
    .POLL_DIV    (PollDiv),
    .DEBOUNCE_CNT(DbCnt),
    .CNT_W       (16)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .enable_i      (enable),
    .avm_address_o (avm_address),
    .avm_read_o    (avm_read),
    .avm_readdata_i(avm_readdata),
    .edge_clr_i    (edge_clr),
    .sw_state_o    (sw_state),
    .sw_changed_o  (sw_changed),
    .edge_capture_o(edge_capture),
    .irq_o         (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign pio_ret = alt_mode ? {7'b0, alt_phase} : pio_val;

  // Registered slave: data valid the cycle after the strobe, junk otherwise.
  always @(posedge clk) begin
    if (reset) alt_phase <= 1'b1;
    else if (avm_read) alt_phase <= ~alt_phase;
    avm_readdata <= avm_read ? {24'hC0FFEE, pio_ret} : 32'hFFFF_FFFF;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: samples on the falling edge, runs the debounce model and scoreboard.
  initial begin : monitor
    sb_entry_t  ent;
    logic [7:0] m_cand;
    logic [7:0] m_state;
    int         m_cnt;
    int         last_ref;
    bit         ref_is_read;
    m_cand = '0; m_state = '0; m_cnt = 0; last_ref = 0; ref_is_read = 1'b0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (sw_changed) chg_count++;
      if (sb_q.size() > 0 && sb_q[0].due == ncyc) begin
        ent = sb_q.pop_front();
        check("sb_sw_state", 32'(sw_state), 32'(ent.st));
        check("sb_sw_changed", 32'(sw_changed), 32'(ent.chg));
      end else if (sw_changed) begin
        check("spurious_sw_changed", 32'(sw_changed), 32'(0));
      end
      if (avm_read) begin
        n_reads++;
        check("read_gap", 32'(ncyc - last_ref), 32'(ref_is_read ? PollDiv : PollDiv + 1));
        last_ref    = ncyc;
        ref_is_read = 1'b1;
      end
      if (reset) begin
        sb_q.delete();
        m_cand = '0; m_state = '0; m_cnt = 0;
      end else if (avm_read) begin
        if (pio_ret == m_cand) begin
          m_cnt = (m_cnt >= DbCnt) ? DbCnt : m_cnt + 1;
        end else begin
          m_cand = pio_ret;
          m_cnt  = 1;
        end
        ent.due = ncyc + 3;
        ent.chg = (m_cnt >= DbCnt) && (m_cand != m_state);
        if (ent.chg) m_state = m_cand;
        ent.st = m_state;
        sb_q.push_back(ent);
      end
      if (reset || !enable) begin
        last_ref    = ncyc;
        ref_is_read = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
  endtask

  // Returns in the read cycle of the n-th strobe.
  task automatic wait_reads(input int n);
    int seen = 0;
    for (int k = 0; k < 40 * n && seen < n; k++) begin
      step();
      if (avm_read) seen++;
    end
    if (seen < n) check("read_timeout", 32'(seen), 32'(n));
  endtask

  // Returns in the cycle sw_changed is high.
  task automatic wait_commit(input int budget);
    for (int k = 0; k < budget; k++) begin
      step();
      if (sw_changed) break;
    end
    if (!sw_changed) check("commit_timeout", 32'(sw_changed), 32'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, n_checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int r0;
    int c0;
    int k;
    reset = 1'b1; enable = 1'b1; edge_clr = '0; pio_val = 8'h00; alt_mode = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    check("rst_avm_read", 32'(avm_read), 32'(0));
    check("rst_avm_address", 32'(avm_address), 32'(0));
    check("rst_sw_state", 32'(sw_state), 32'(0));
    check("rst_sw_changed", 32'(sw_changed), 32'(0));
    check("rst_edge", 32'(edge_capture), 32'(0));
    check("rst_irq", 32'(irq), 32'(0));

    // Reset during a READ after a commit, then stale-state probe.
    pio_val = 8'h33;
    wait_commit(200);
    check("t1_pre_state", 32'(sw_state), 32'h33);
    wait_reads(1);
    reset = 1'b1;
    step();
    check("t1_read_low", 32'(avm_read), 32'(0));
    check("t1_state0", 32'(sw_state), 32'(0));
    check("t1_edge0", 32'(edge_capture), 32'(0));
    check("t1_irq0", 32'(irq), 32'(0));
    check("t1_chg0", 32'(sw_changed), 32'(0));
    repeat (2) step();
    reset = 1'b0;
    c0 = chg_count;
    wait_reads(1);
    repeat (4) step();
    check("t1_no_stale_commit", 32'(sw_state), 32'(0));
    check("t1_no_pulse", 32'(chg_count - c0), 32'(0));

    // Stable 0x5A.
    do_reset();
    pio_val = 8'h5A;
    r0 = n_reads;
    c0 = chg_count;
    wait_commit(200);
    check("t2_reads_to_commit", 32'(n_reads - r0), 32'(4));
    check("t2_state", 32'(sw_state), 32'h5A);
    check("t2_edge", 32'(edge_capture), IrqEn ? 32'h5A : 32'h0);
    check("t2_irq_lag", 32'(irq), 32'(0));
    step();
    check("t2_irq", 32'(irq), 32'(IrqEn));
    check("t2_pulse_one_cycle", 32'(sw_changed), 32'(0));
    wait_reads(3);
    repeat (4) step();
    check("t2_single_pulse", 32'(chg_count - c0), 32'(1));
    check("t2_edge_hold", 32'(edge_capture), IrqEn ? 32'h5A : 32'h0);

    // Bouncing input.
    do_reset();
    alt_mode = 1'b1;
    c0 = chg_count;
    wait_reads(10);
    repeat (4) step();
    check("t3_state", 32'(sw_state), 32'(0));
    check("t3_no_pulse", 32'(chg_count - c0), 32'(0));
    alt_mode = 1'b0;

    // Clear collides with a 0x00 -> 0x80 commit.
    do_reset();
    pio_val = 8'h01;
    wait_commit(200);
    pio_val = 8'h00;
    wait_commit(200);
    check("t4_state00", 32'(sw_state), 32'h00);
    pio_val = 8'h80;
    wait_reads(4);
    step();
    step();
    check("t4_edge_before", 32'(edge_capture), IrqEn ? 32'h01 : 32'h0);
    check("t4_irq_before", 32'(irq), 32'(IrqEn));
    edge_clr = 8'hFF;
    step();
    edge_clr = 8'h00;
    check("t4_commit", 32'(sw_changed), 32'(1));
    check("t4_state80", 32'(sw_state), 32'h80);
    check("t4_edge_set_wins", 32'(edge_capture), IrqEn ? 32'h80 : 32'h0);
    check("t4_irq_c", 32'(irq), 32'(IrqEn));
    step();
    check("t4_irq_c1", 32'(irq), 32'(IrqEn));
    edge_clr = 8'h80;
    step();
    edge_clr = 8'h00;
    check("t4_cleared", 32'(edge_capture), 32'(0));
    check("t4_irq_trails", 32'(irq), 32'(IrqEn));
    step();
    check("t4_irq_off", 32'(irq), 32'(0));

    // Disable in the READ cycle of the committing poll.
    do_reset();
    pio_val = 8'h5A;
    wait_reads(4);
    enable = 1'b0;
    repeat (3) step();
    check("t5_commit_completes", 32'(sw_changed), 32'(1));
    check("t5_state", 32'(sw_state), 32'h5A);
    r0 = n_reads;
    repeat (20) step();
    check("t5_no_reads_disabled", 32'(n_reads - r0), 32'(0));
    enable = 1'b1;
    k = 0;
    while (k < 20) begin
      step();
      k++;
      if (avm_read) break;
    end
    check("t5_first_read_delay", 32'(k), 32'(PollDiv));

    enable = 1'b0;
    repeat (10) step();
    check("sb_drained", 32'(sb_q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
